// File: rtl/uart_pkg.sv
// Constants and FSM state type shared by the UART transmitter and the
// oversampling receiver, so both sides agree on frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam int UART_SAMPLES_PER_BIT = 5;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/ready handshake between a word producer and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;

    modport master (output tx_start, output tx_data, input tx_ready, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_ready, output tx_busy);

endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB-first, optional even parity
// (UART_TX_PARITY_EN), STOP_BITS stop bits; each bit lasts SAMPLES_PER_BIT ENABLE ticks.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = UART_SAMPLES_PER_BIT,
    parameter int DATA_BITS       = UART_DATA_BITS,
    parameter int STOP_BITS       = 1
) (
    input  logic            clk,
    input  logic            res,
    input  logic            ENABLE,
    uart_tx_frame_if.slave  req,
    output logic            TX,
    output logic            priznak_end_transmitter
);

    localparam int TICK_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + STOP_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t            state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tx_line;
    logic                 end_pulse;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign bit_end    = ENABLE && (tick_cnt == TICK_LAST);
    assign shift_next = shift >> 1;

    // The line is registered so the next bit appears on the same edge that ends the current one.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            tx_line   <= 1'b1;
            end_pulse <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            end_pulse <= 1'b0;
            if (state == IDLE) begin
                tx_line <= 1'b1;
                if (req.tx_start) begin
                    shift    <= req.tx_data;
                    state    <= START;
                    tx_line  <= 1'b0;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= ^req.tx_data;
`endif
                end
            end else if (ENABLE) begin
                if (!bit_end) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end else begin
                    tick_cnt <= '0;
                    case (state)
                        START: begin
                            state   <= DATA;
                            tx_line <= shift[0];
                        end
                        DATA: begin
                            shift <= shift_next;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                tx_line <= parity_bit;
`else
                                state   <= STOP;
                                tx_line <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx_line <= shift_next[0];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state   <= STOP;
                            tx_line <= 1'b1;
                        end
`endif
                        STOP: begin
                            if (bit_cnt == STOP_LAST) begin
                                state     <= IDLE;
                                bit_cnt   <= '0;
                                end_pulse <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign req.tx_ready            = (state == IDLE);
    assign req.tx_busy             = (state != IDLE);
    assign TX                      = tx_line;
    assign priznak_end_transmitter = end_pulse;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized frames for uart_tx_frame, checked against a bit-list frame model.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int SPB = UART_SAMPLES_PER_BIT;
    localparam int DB  = UART_DATA_BITS;
    localparam int SB  = 1;

    logic clk = 1'b0;
    logic res;
    logic ENABLE;
    logic TX;
    logic end_p;

    uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

    uart_tx_frame #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_BITS(DB),
        .STOP_BITS(SB)
    ) dut (
        .clk(clk),
        .res(res),
        .ENABLE(ENABLE),
        .req(bus),
        .TX(TX),
        .priznak_end_transmitter(end_p)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int gap   = 3;
    bit exp_bits[$];

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame as a list of line levels, one entry per bit period.
    task automatic modelFrame(input logic [7:0] d);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back(^d);
`endif
        for (int s = 0; s < SB; s++) exp_bits.push_back(1'b1);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit en_on_accept);
        int n = 0;
        while (!bus.tx_ready && n < 500) begin
            step();
            n++;
        end
        checkOutput("ready_before_start", bus.tx_ready, 1);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        ENABLE       = en_on_accept;
        step();
        bus.tx_start = 1'b0;
        ENABLE       = 1'b0;
        checkOutput("accept_tx_low", TX, 0);
        checkOutput("accept_busy", bus.tx_busy, 1);
        checkOutput("accept_not_ready", bus.tx_ready, 0);
    endtask

    task automatic runFrame(input logic [7:0] d, input int stop_at, input int inject_at, output int pulses);
        int nt;
        int last;
        modelFrame(d);
        nt     = exp_bits.size() * SPB;
        last   = (stop_at != 0) ? stop_at : nt;
        pulses = 0;
        for (int k = 1; k <= last; k++) begin
            repeat (gap) step();
            checkOutput($sformatf("tx_bit%0d_tick%0d", (k - 1) / SPB, k), TX, exp_bits[(k - 1) / SPB]);
            if (inject_at > 0 && k == inject_at) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = ~d;
            end
            if (inject_at > 0 && k == inject_at + 1) bus.tx_start = 1'b0;
            ENABLE = 1'b1;
            step();
            ENABLE = 1'b0;
            if (end_p) pulses++;
            checkOutput($sformatf("end_pulse_tick%0d", k), end_p, (k == nt));
        end
        if (stop_at == 0) begin
            checkOutput("frame_end_ready", bus.tx_ready, 1);
            checkOutput("frame_end_tx_high", TX, 1);
        end
    endtask

    initial begin
        int p;
        int extra;
        logic [7:0] d;

        res          = 1'b0;
        ENABLE       = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = '0;
        step();
        step();
        checkOutput("reset_tx", TX, 1);
        checkOutput("reset_ready", bus.tx_ready, 1);
        checkOutput("reset_busy", bus.tx_busy, 0);
        checkOutput("reset_end", end_p, 0);
        res = 1'b1;
        step();

        // Basic frame, ENABLE every 4 clocks.
        applyStimulus(8'hA5, 1'b0);
        runFrame(8'hA5, 0, 0, p);
        step();
        checkOutput("end_pulse_width", end_p, 0);
        checkOutput("a5_pulses", p[15:0], 1);

        // ENABLE coincident with accept must not count.
        applyStimulus(8'h3C, 1'b1);
        runFrame(8'h3C, 0, 0, p);
        step();

        // Request while busy is dropped, not queued.
        applyStimulus(8'hFF, 1'b0);
        runFrame(8'hFF, 0, 20, p);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (end_p) extra++;
        end
        checkOutput("busy_req_pulses", p[15:0], 1);
        checkOutput("busy_req_no_extra", extra[15:0], 0);
        checkOutput("busy_req_idle_tx", TX, 1);
        checkOutput("busy_req_idle_ready", bus.tx_ready, 1);

        // Back-to-back with tx_start held; data change mid-frame is ignored.
        bus.tx_data  = 8'h01;
        bus.tx_start = 1'b1;
        step();
        checkOutput("b2b_first_tx_low", TX, 0);
        bus.tx_data = 8'h80;
        runFrame(8'h01, 0, 0, p);
        checkOutput("b2b_first_pulse", end_p, 1);
        step();
        bus.tx_start = 1'b0;
        checkOutput("b2b_second_tx_low", TX, 0);
        checkOutput("b2b_second_busy", bus.tx_busy, 1);
        checkOutput("b2b_pulse_width", end_p, 0);
        runFrame(8'h80, 0, 0, p);
        step();

        // Reset mid-frame aborts without an end pulse.
        applyStimulus(8'hC3, 1'b0);
        runFrame(8'hC3, 23, 0, p);
        res = 1'b0;
        #1;
        checkOutput("abort_tx", TX, 1);
        checkOutput("abort_ready", bus.tx_ready, 1);
        checkOutput("abort_busy", bus.tx_busy, 0);
        checkOutput("abort_end", end_p, 0);
        step();
        step();
        checkOutput("abort_end_later", end_p, 0);
        res = 1'b1;
        step();
        applyStimulus(8'h55, 1'b0);
        runFrame(8'h55, 0, 0, p);
        step();

        applyStimulus(8'h07, 1'b0);
        runFrame(8'h07, 0, 0, p);
        step();

        // Long ENABLE gaps: line must hold its level.
        gap = 25;
        applyStimulus(8'h96, 1'b0);
        runFrame(8'h96, 0, 0, p);
        step();

        for (int r = 0; r < 6; r++) begin
            gap = int'($urandom_range(0, 6));
            d   = 8'($urandom);
            applyStimulus(d, 1'($urandom_range(0, 1)));
            runFrame(d, 0, 0, p);
            step();
            checkOutput("rand_pulse_width", end_p, 0);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
